// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer width helper and Gray-code utilities shared by both FIFO clock domains
package fifo_pkg;

    function automatic int ptr_w(input int depth);
        return depth + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // A write pointer equals this value exactly when it is one full lap ahead of g.
    function automatic logic [31:0] full_cmp(input logic [31:0] g, input int w);
        return g ^ (32'd3 << (w - 2));
    endfunction

endpackage

// File: rtl/fifo_wptr_full_sync_r2w.sv
// sync_r2w: multi-flop synchroniser bringing the read-domain Gray pointer into w_clk
module sync_r2w
    import fifo_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             w_clk,
    input  logic             wrst_n,
    input  logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] synced
);
    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // shift the pointer through the flop chain; reset clears every stage
    always_ff @(posedge w_clk) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= ptr;
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign synced = stage[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer, RAM address, full/almost-full/level and sticky overflow
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int MEMORY_DEPTH       = 4,
    parameter int ALMOST_FULL_THRESH = 14,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                    w_clk,
    input  logic                    wrst_n,
    input  logic                    w_en,
    input  logic [MEMORY_DEPTH:0]   r_ptr,
    output logic                    w_full,
    output logic                    w_almost_full,
    output logic                    w_overflow,
    output logic [MEMORY_DEPTH:0]   w_ptr,
    output logic [MEMORY_DEPTH-1:0] w_addr,
    output logic [MEMORY_DEPTH:0]   w_level
);
    localparam int PTR_W = ptr_w(MEMORY_DEPTH);
    localparam logic [PTR_W-1:0] DEPTH  = PTR_W'(1 << MEMORY_DEPTH);
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(ALMOST_FULL_THRESH);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > (1 << MEMORY_DEPTH)) begin : g_bad_thresh
        $error("ALMOST_FULL_THRESH out of range");
    end

    logic [PTR_W-1:0] w_bin, w_bnext, w_gnext, wq_rptr, wq_rbin, level_next;
    logic             wr_ok, full_next;

    sync_r2w #(.WIDTH(PTR_W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .w_clk  (w_clk),
        .wrst_n (wrst_n),
        .ptr    (r_ptr),
        .synced (wq_rptr)
    );

    // next pointer values and flags, all judged against the already-synchronised read pointer
    always_comb begin
        wr_ok      = w_en & ~w_full;
        w_bnext    = w_bin + PTR_W'(wr_ok);
        w_gnext    = PTR_W'(bin2gray(32'(w_bnext)));
        wq_rbin    = PTR_W'(gray2bin(32'(wq_rptr)));
        full_next  = w_gnext == PTR_W'(full_cmp(32'(wq_rptr), PTR_W));
        level_next = w_bnext - wq_rbin;
    end

    assign w_addr = w_bin[MEMORY_DEPTH-1:0];

    // register pointers and flags from next-state so full rises on the edge that fills the last slot
    always_ff @(posedge w_clk) begin
        if (!wrst_n) begin
            w_bin         <= '0;
            w_ptr         <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_overflow    <= 1'b0;
            w_level       <= '0;
        end else begin
            w_bin         <= w_bnext;
            w_ptr         <= w_gnext;
            w_full        <= full_next;
            w_almost_full <= level_next >= AF_LVL;
            w_overflow    <= w_overflow | (w_en & w_full);
            w_level       <= level_next;
        end
    end

    a_full_level: assert property (@(posedge w_clk) disable iff (!wrst_n) w_full |-> w_level == DEPTH);

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: scoreboard bench for the write-side pointer/full logic
module tb_fifo_wptr_full;
    logic       w_clk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       w_en = 1'b0;
    logic [4:0] r_ptr = '0;
    logic       w_full, w_almost_full, w_overflow;
    logic [4:0] w_ptr, w_level;
    logic [3:0] w_addr;

    typedef struct packed {
        logic [4:0] ptr;
        logic [3:0] addr;
        logic       full;
        logic       af;
        logic       ovf;
        logic [4:0] level;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] m_bin, m_s0, m_s1;
    logic       m_full, m_ovf;

    fifo_wptr_full dut (
        .w_clk         (w_clk),
        .wrst_n        (wrst_n),
        .w_en          (w_en),
        .r_ptr         (r_ptr),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_overflow    (w_overflow),
        .w_ptr         (w_ptr),
        .w_addr        (w_addr),
        .w_level       (w_level)
    );

    // free-running write clock
    always #5 w_clk = ~w_clk;

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [4:0] rp, input logic rn);
        exp_t       e;
        logic [4:0] lvl;
        w_en   = en;
        r_ptr  = rp;
        wrst_n = rn;
        if (!rn) begin
            m_bin = '0; m_s0 = '0; m_s1 = '0; m_full = 1'b0; m_ovf = 1'b0;
            e = '0;
        end else begin
            m_ovf = m_ovf | (en & m_full);
            if (en && !m_full) m_bin = m_bin + 5'd1;
            lvl     = m_bin - g2b(m_s1);
            m_full  = lvl == 5'd16;
            m_s1    = m_s0;
            m_s0    = rp;
            e.ptr   = b2g(m_bin);
            e.addr  = m_bin[3:0];
            e.full  = m_full;
            e.af    = lvl >= 5'd14;
            e.ovf   = m_ovf;
            e.level = lvl;
        end
        sb.push_back(e);
        @(posedge w_clk);
        #1;
        e = sb.pop_front();
        check("sb_ptr",   32'(w_ptr),         32'(e.ptr));
        check("sb_addr",  32'(w_addr),        32'(e.addr));
        check("sb_full",  32'(w_full),        32'(e.full));
        check("sb_af",    32'(w_almost_full), 32'(e.af));
        check("sb_ovf",   32'(w_overflow),    32'(e.ovf));
        check("sb_level", 32'(w_level),       32'(e.level));
    endtask

    // bound total simulated time
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // directed scenarios followed by constrained-random traffic
    initial begin
        logic [4:0] prev;
        logic [4:0] rb;
        logic       saw_wrap;
        logic       en;
        step(0, 5'd0, 0);
        step(0, 5'd0, 0);
        check("rst_addr",  32'(w_addr),     32'd0);
        check("rst_ptr",   32'(w_ptr),      32'd0);
        check("rst_level", 32'(w_level),    32'd0);
        check("rst_full",  32'(w_full),     32'd0);

        for (int i = 0; i < 16; i++) begin
            check("addr_seq", 32'(w_addr), 32'(i));
            step(1, 5'd0, 1);
            check("gray_seq", 32'(w_ptr), 32'((i + 1) ^ ((i + 1) >> 1)));
            check("af_rise",  32'(w_almost_full), 32'(i + 1 >= 14));
            check("full_rise", 32'(w_full), 32'(i == 15));
        end
        check("level_16", 32'(w_level), 32'd16);

        for (int i = 0; i < 3; i++) begin
            step(1, 5'd0, 1);
            check("ptr_hold",  32'(w_ptr),      32'h18);
            check("addr_hold", 32'(w_addr),     32'd0);
            check("ovf_set",   32'(w_overflow), 32'd1);
        end

        step(0, 5'b00110, 1);
        step(0, 5'b00110, 1);
        check("full_stale", 32'(w_full), 32'd1);
        step(0, 5'b00110, 1);
        check("full_clr",   32'(w_full),        32'd0);
        check("level_12",   32'(w_level),       32'd12);
        check("af_clr",     32'(w_almost_full), 32'd0);
        check("ovf_sticky", 32'(w_overflow),    32'd1);

        saw_wrap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev = w_ptr;
            step(1, b2g(m_bin - 5'd2), 1);
            check("one_bit", 32'($countones(w_ptr ^ prev)), 32'd1);
            check("no_full", 32'(w_full), 32'd0);
            if (prev == 5'b10000 && w_ptr == 5'b00000) saw_wrap = 1'b1;
        end
        check("wrap_seen", 32'(saw_wrap), 32'd1);

        step(0, 5'd0, 0);
        for (int i = 0; i < 9; i++) step(1, 5'd0, 1);
        check("level_9", 32'(w_level), 32'd9);
        step(1, 5'd0, 0);
        check("mid_rst_ptr",   32'(w_ptr),         32'd0);
        check("mid_rst_addr",  32'(w_addr),        32'd0);
        check("mid_rst_level", 32'(w_level),       32'd0);
        check("mid_rst_full",  32'(w_full),        32'd0);
        check("mid_rst_af",    32'(w_almost_full), 32'd0);
        check("mid_rst_ovf",   32'(w_overflow),    32'd0);
        step(0, 5'd0, 1);
        check("no_write_addr", 32'(w_addr), 32'd0);
        check("no_write_ptr",  32'(w_ptr),  32'd0);

        step(0, 5'd0, 0);
        rb = '0;
        for (int i = 0; i < 10000; i++) begin
            en = (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 1) == 1 && rb != m_bin) rb = rb + 5'd1;
            step(en, b2g(rb), 1);
            check("lvl_max", 32'(w_level <= 5'd16), 32'd1);
            check("full_eq", 32'(w_full), 32'(w_level == 5'd16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-domain control stage of the asynchronous FIFO; sits directly upstream of the read-side pointer/empty logic and drives its `w_ptr` input.
- Holds the binary and Gray write pointers and generates the dual-port RAM write address.
- Synchronises the read-side Gray pointer into `w_clk` and derives full, almost-full, fill level and a sticky overflow flag.
- All state runs on the single write clock.

Parameters:
MEMORY_DEPTH, 4, address width in bits; FIFO holds 2**MEMORY_DEPTH words; pointers are MEMORY_DEPTH+1 bits
ALMOST_FULL_THRESH, 14, w_almost_full asserts when fill level >= this value; legal range 1..2**MEMORY_DEPTH
SYNC_STAGES, 2, flops in the r_ptr-to-w_clk synchroniser; minimum 2

Ports:
w_clk  input  1  write clock; sole clock of this block
wrst_n  input  1  synchronous, active-low reset, sampled on rising w_clk
w_en  input  1  write request from producer
r_ptr  input  MEMORY_DEPTH+1  Gray read pointer from the read clock domain (asynchronous to w_clk)
w_full  output  1  FIFO full; writes are ignored while high
w_almost_full  output  1  fill level >= ALMOST_FULL_THRESH
w_overflow  output  1  sticky: a write was attempted while full
w_ptr  output  MEMORY_DEPTH+1  registered Gray write pointer, sent to the read domain
w_addr  output  MEMORY_DEPTH  RAM write address (low bits of the binary pointer)
w_level  output  MEMORY_DEPTH+1  write-side fill level, range 0..2**MEMORY_DEPTH

Behaviour:
Reset:
- wrst_n low at a rising w_clk clears every register to 0: binary pointer, Gray pointer, all synchroniser stages, w_full, w_almost_full, w_overflow, w_level.
- w_addr is therefore 0 one edge after reset is sampled.
- Reset asserted mid-burst discards all in-flight state on that edge; w_en is ignored on that edge.

Write acceptance:
- wr_ok = w_en & ~w_full, using the registered w_full.
- On wr_ok: w_bnext = w_bin + 1, modulo 2**(MEMORY_DEPTH+1); otherwise w_bnext = w_bin.
- w_gnext = w_bnext ^ (w_bnext >> 1).
- w_bin and w_ptr load w_bnext and w_gnext every edge.
- w_addr = w_bin[MEMORY_DEPTH-1:0]. This is the address of the word written on the current edge, so the RAM write enable is wr_ok.
- Latency: a write accepted at edge k moves w_ptr and w_addr immediately after edge k.

Synchroniser:
- r_ptr passes through SYNC_STAGES flops to give wq_rptr. No other logic may sample r_ptr directly.
- wq_rbin = Gray-to-binary(wq_rptr).

Full, level and flags (all registered from next-state values):
- Full condition: w_gnext == {~wq_rptr[MSB:MSB-1], wq_rptr[MSB-2:0]}.
- w_full loads the full condition each edge. It must rise on the same edge that writes the last free slot.
- w_level loads (w_bnext - wq_rbin) modulo 2**(MEMORY_DEPTH+1).
- w_full high must always coincide with w_level == 2**MEMORY_DEPTH. This is an assertion.
- w_almost_full loads (level_next >= ALMOST_FULL_THRESH).
- w_overflow is set on any edge with w_en & w_full and is cleared only by reset.

Pessimism and latency:
- A read-side pointer change stable before edge k becomes visible in w_full and w_level after edge k+SYNC_STAGES.
- Full and level may therefore be stale-high, never stale-low.

Boundary conditions:
- Pointer wrap: the binary pointer wraps 2**(MEMORY_DEPTH+1)-1 -> 0 with no special case. The Gray code changes exactly one bit per increment, including at the wrap.
- Write on the last free slot while a read frees a slot in the same cycle: w_full still asserts. It deasserts SYNC_STAGES edges after the read pointer reaches the synchroniser.
- w_en held high while full: no pointer movement, w_overflow goes high, and w_addr stays fixed.

Decomposition:
- Package fifo_pkg holds:
  - localparam PTR_W = MEMORY_DEPTH+1 helper function
  - bin2gray and gray2bin functions, shared with the read side
  - the full-compare function (invert top two Gray bits)
- One sub-module: sync_r2w, an SYNC_STAGES-deep flop chain with synchronous active-low reset on w_clk, parameterised by width.
- All pointer, flag and level logic stays in fifo_wptr_full.

Test Plan:
(All scenarios use default parameters.)
- Reset, then w_en=1 for 16 edges with r_ptr=0:
  - w_addr steps 0..15.
  - w_ptr Gray sequence 0,1,3,2,6,...
  - w_full rises on the edge of the 16th write, with w_level=16.
  - w_almost_full rises when w_level=14.
- Full, w_en held 3 more cycles: w_ptr unchanged at Gray(16)=5'b11000, and w_overflow=1 and stays 1 until wrst_n=0.
- From full, drive r_ptr=Gray(4)=5'b00110: w_full=0 and w_level=12 exactly 2 edges later; w_almost_full=0.
- Wrap: with r_ptr tracking the write pointer minus 2, write 40 words. Check:
  - binary pointer wraps 31->0
  - exactly one w_ptr bit changes per write
  - w_full never asserts
- Assert wrst_n=0 for one edge while w_en=1 at w_level=9: next cycle all outputs are 0, and the write in that cycle is not accepted.
- Random w_en and random monotonic Gray r_ptr over 10k cycles. Check against a reference model that:
  - w_level never exceeds 16
  - w_full matches w_level==16 on every cycle
